// File: rtl/buswrite_dram_queue_pkg.sv
// buswrite_dram_queue_pkg: shared SDRAM address field widths, handshake states, sector size
package buswrite_dram_queue_pkg;
   localparam int CYL_W         = 8;
   localparam int HEAD_W        = 1;
   localparam int SECT_W        = 2;
   localparam int OFFS_W        = 9;
   localparam int ADDR_W        = 20;
   localparam int DATA_W        = 16;
   localparam int BASE_W        = CYL_W + HEAD_W + SECT_W;
   localparam int ENTRY_W       = ADDR_W + DATA_W;
   localparam int WORDS_MAX_DEF = 321;
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} hs_state_t;
endpackage

// File: rtl/sync_fifo_addr_data.sv
// sync_fifo_addr_data: DEPTH x W register FIFO with flush; ports: i_clock, i_reset, i_flush,
// i_wr_en/i_wr_data (push), i_rd_en (pop), o_head/o_next (first two entries), o_count, o_full, o_empty
module sync_fifo_addr_data #(
   parameter int DEPTH = 4,
   parameter int W     = 36
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_flush,
   input  logic                     i_wr_en,
   input  logic                     i_rd_en,
   input  logic [W-1:0]             i_wr_data,
   output logic [W-1:0]             o_head,
   output logic [W-1:0]             o_next,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [PW-1:0] w_rptr_nx;
   logic          w_wr, w_rd;
   assign w_wr      = i_wr_en & ~i_flush;
   assign w_rd      = i_rd_en & ~i_flush;
   assign w_rptr_nx = r_rptr + 1'b1;
   assign o_head    = r_mem[r_rptr];
   assign o_next    = r_mem[w_rptr_nx];
   assign o_full    = o_count == (PW+1)'(DEPTH);
   assign o_empty   = o_count == '0;
   always_ff @(posedge i_clock) begin
      if (i_reset || i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         o_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= w_rptr_nx;
         o_count <= o_count + (PW+1)'(w_wr) - (PW+1)'(w_rd);
      end
   end
   always_ff @(posedge i_clock)
      if (w_wr && !i_reset) r_mem[r_wptr] <= i_wr_data;
endmodule

// File: rtl/buswrite_dram_queue.sv
// buswrite_dram_queue: tags bus write words with SDRAM addresses, queues them, offers them via req/ack.
// Ports: clock, reset, flush; load_address_in + cylinder/head/sector (sector base); write_enbl_in +
// writedata_in (word strobe); dram_ack in, dram_req/dram_addr/dram_data out; writeack_out,
// overflow_error, queue_count. Macro SECTOR_BOUNDS_CHECK_EN drops words at offset >= WORDS_MAX.
module buswrite_dram_queue
   import buswrite_dram_queue_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int WORDS_MAX = WORDS_MAX_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   load_address_in,
   input  logic [CYL_W-1:0]       cylinder,
   input  logic [HEAD_W-1:0]      head,
   input  logic [SECT_W-1:0]      sector,
   input  logic                   write_enbl_in,
   input  logic [DATA_W-1:0]      writedata_in,
   input  logic                   dram_ack,
   output logic                   dram_req,
   output logic [ADDR_W-1:0]      dram_addr,
   output logic [DATA_W-1:0]      dram_data,
   output logic                   writeack_out,
   output logic                   overflow_error,
   output logic [$clog2(DEPTH):0] queue_count
);
   localparam int CW = $clog2(DEPTH) + 1;
   hs_state_t          r_state;
   logic [BASE_W-1:0]  r_base;
   logic [OFFS_W-1:0]  r_offset;
   logic [ENTRY_W-1:0] r_head;
   logic [BASE_W-1:0]  w_base;
   logic [OFFS_W-1:0]  w_off, w_off_next;
   logic [ENTRY_W-1:0] w_entry, w_fifo_head, w_fifo_next;
   logic [CW-1:0]      w_count;
   logic               w_oob, w_wr_req, w_pop, w_push, w_drop, w_full, w_empty, w_pending;
   // A same-cycle address load applies to the word arriving with it
   assign w_base = load_address_in ? {cylinder, head, sector} : r_base;
   assign w_off  = load_address_in ? '0 : r_offset;
`ifdef SECTOR_BOUNDS_CHECK_EN
   localparam logic [OFFS_W-1:0] LIMIT = OFFS_W'(WORDS_MAX);
   assign w_oob      = w_off >= LIMIT;
   assign w_off_next = w_oob ? LIMIT : w_off + 1'b1;
`else
   assign w_oob      = 1'b0;
   assign w_off_next = w_off + 1'b1;
`endif
   assign w_wr_req  = write_enbl_in & ~flush;
   assign w_pop     = (r_state == REQ) & dram_ack & ~flush;
   // A pop in the same cycle frees the slot a full queue needs
   assign w_push    = w_wr_req & ~w_oob & (~w_full | w_pop);
   assign w_drop    = w_wr_req & ~w_push;
   assign w_entry   = {w_base, w_off, writedata_in};
   assign w_pending = ~w_empty | w_push;
   assign dram_addr   = r_head[ENTRY_W-1:DATA_W];
   assign dram_data   = r_head[DATA_W-1:0];
   assign queue_count = w_count;
   sync_fifo_addr_data #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
      .i_clock   (clock),
      .i_reset   (reset),
      .i_flush   (flush),
      .i_wr_en   (w_push),
      .i_rd_en   (w_pop),
      .i_wr_data (w_entry),
      .o_head    (w_fifo_head),
      .o_next    (w_fifo_next),
      .o_count   (w_count),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         r_base         <= '0;
         r_offset       <= '0;
         overflow_error <= 1'b0;
      end else begin
         r_base         <= w_base;
         r_offset       <= w_wr_req ? w_off_next : w_off;
         overflow_error <= w_drop | (overflow_error & ~load_address_in);
      end
   end
   // r_head mirrors the FIFO head whenever the queue is non-empty, so the offered
   // address/data are registered and only move after a pop, a flush or a push into an empty queue
   always_ff @(posedge clock) begin
      if (reset || flush)
         r_head <= '0;
      else if (w_pop && w_count > CW'(1))
         r_head <= w_fifo_next;
      else if (w_push && w_count == (w_pop ? CW'(1) : CW'(0)))
         r_head <= w_entry;
      else if (!w_empty && !w_pop)
         r_head <= w_fifo_head;
   end
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         r_state      <= IDLE;
         dram_req     <= 1'b0;
         writeack_out <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               writeack_out <= 1'b0;
               dram_req     <= w_pending;
               r_state      <= w_pending ? REQ : IDLE;
            end
            REQ: begin
               writeack_out <= dram_ack;
               dram_req     <= ~dram_ack;
               r_state      <= dram_ack ? HOLD : REQ;
            end
            HOLD: begin
               writeack_out <= 1'b0;
               dram_req     <= w_pending;
               r_state      <= w_pending ? REQ : IDLE;
            end
            default: begin
               writeack_out <= 1'b0;
               dram_req     <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_buswrite_dram_queue.sv
// tb_buswrite_dram_queue: directed and random stimulus against a queue-based reference model
module tb_buswrite_dram_queue;
   localparam int DEPTH = 4;
   localparam int WMAX  = 321;
`ifdef SECTOR_BOUNDS_CHECK_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif
   logic        clock = 1'b0, reset, flush, load_address_in, head, write_enbl_in, dram_ack;
   logic [7:0]  cylinder;
   logic [1:0]  sector;
   logic [15:0] writedata_in, dram_data;
   logic        dram_req, writeack_out, overflow_error;
   logic [19:0] dram_addr;
   logic [2:0]  queue_count;
   buswrite_dram_queue #(.DEPTH(DEPTH), .WORDS_MAX(WMAX)) dut (
      .clock(clock), .reset(reset), .flush(flush), .load_address_in(load_address_in),
      .cylinder(cylinder), .head(head), .sector(sector), .write_enbl_in(write_enbl_in),
      .writedata_in(writedata_in), .dram_ack(dram_ack), .dram_req(dram_req),
      .dram_addr(dram_addr), .dram_data(dram_data), .writeack_out(writeack_out),
      .overflow_error(overflow_error), .queue_count(queue_count)
   );
   always #5 clock = ~clock;
   int vectors = 0, miscompares = 0;
   int m_base = 0, m_off = 0, wack_total = 0;
   bit m_ovf = 0, m_req = 0, m_wack = 0;
   logic [35:0] mq[$];
   int acked[$];
   logic [7:0] cur_c = 0;
   logic       cur_h = 0;
   logic [1:0] cur_s = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step(input bit ld, input bit we, input bit ack, input bit fl, input logic [15:0] d);
      bit pop;
      load_address_in = ld; write_enbl_in = we; dram_ack = ack; flush = fl;
      cylinder = cur_c; head = cur_h; sector = cur_s; writedata_in = d;
      pop = m_req && ack && !fl;
      if (pop) begin
         acked.push_back(int'(mq[0][35:16]));
         void'(mq.pop_front());
      end
      if (ld) begin
         m_base = int'(cur_c) * 4096 + int'(cur_h) * 2048 + int'(cur_s) * 512;
         m_off = 0;
         m_ovf = 0;
      end
      if (we && !fl) begin
         if (BOUNDS && m_off >= WMAX) m_ovf = 1;
         else if (mq.size() == DEPTH) m_ovf = 1;
         else mq.push_back({20'(m_base + m_off), d});
         m_off = BOUNDS ? (m_off >= WMAX ? WMAX : m_off + 1) : (m_off + 1) % 512;
      end
      if (fl) mq.delete();
      m_wack = pop;
      m_req = fl ? 1'b0 : pop ? 1'b0 : m_req ? 1'b1 : (mq.size() > 0);
      @(posedge clock);
      #1;
      if (m_wack) wack_total++;
      chk("dram_req", dram_req, m_req);
      chk("writeack_out", writeack_out, m_wack);
      chk("queue_count", queue_count, mq.size());
      chk("overflow_error", overflow_error, m_ovf);
      if (m_req) begin
         chk("dram_addr", dram_addr, mq[0][35:16]);
         chk("dram_data", dram_data, mq[0][15:0]);
      end
   endtask
   task automatic drain();
      for (int i = 0; i < 60 && (mq.size() > 0 || m_req || m_wack); i++) step(0, 0, m_req, 0, 16'h0);
      chk("drain_timeout", mq.size(), 0);
   endtask
   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int w0;
      reset = 1; flush = 0; load_address_in = 0; write_enbl_in = 0; dram_ack = 0;
      cylinder = 0; head = 0; sector = 0; writedata_in = 0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_req", dram_req, 0);
      chk("rst_addr", dram_addr, 0);
      chk("rst_data", dram_data, 0);
      chk("rst_wack", writeack_out, 0);
      chk("rst_ovf", overflow_error, 0);
      chk("rst_count", queue_count, 0);
      reset = 0;
      // basic three-word sector
      cur_c = 5; cur_h = 1; cur_s = 2;
      acked.delete(); w0 = wack_total;
      step(1, 0, 0, 0, 16'h0);
      step(0, 1, 0, 0, 16'h1111);
      step(0, 1, 0, 0, 16'h2222);
      step(0, 1, 0, 0, 16'h3333);
      drain();
      chk("t1_nacks", wack_total - w0, 3);
      chk("t1_addr0", acked.size() > 0 ? acked[0] : -1, 32'h05C00);
      chk("t1_addr1", acked.size() > 1 ? acked[1] : -1, 32'h05C01);
      chk("t1_addr2", acked.size() > 2 ? acked[2] : -1, 32'h05C02);
      // overflow with a stalled controller
      cur_c = 7; cur_h = 0; cur_s = 0;
      acked.delete();
      step(1, 0, 0, 0, 16'h0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 16'(16'hA000 + i));
      chk("t2_count", queue_count, 4);
      chk("t2_ovf", overflow_error, 1);
      drain();
      chk("t2_nacks", acked.size(), 4);
      step(1, 0, 0, 0, 16'h0);
      chk("t2_ovf_clr", overflow_error, 0);
      // strobe coincident with ack while full
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 16'(16'hB000 + i));
      step(0, 1, 1, 0, 16'hB004);
      chk("t3_count", queue_count, 4);
      chk("t3_ovf", overflow_error, 0);
      drain();
      // new base while words are pending
      cur_c = 9; cur_h = 0; cur_s = 2;
      acked.delete();
      step(1, 0, 0, 0, 16'h0);
      step(0, 1, 0, 0, 16'hC000);
      step(0, 1, 0, 0, 16'hC001);
      cur_s = 3;
      step(1, 0, 0, 0, 16'h0);
      step(0, 1, 0, 0, 16'hC002);
      drain();
      chk("t4_addr0", acked.size() > 0 ? acked[0] : -1, 32'h09400);
      chk("t4_addr1", acked.size() > 1 ? acked[1] : -1, 32'h09401);
      chk("t4_addr2", acked.size() > 2 ? acked[2] : -1, 32'h09600);
      // flush during REQ with a coincident ack
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 16'(16'hD000 + i));
      step(0, 0, 1, 1, 16'h0);
      chk("t5_req", dram_req, 0);
      chk("t5_count", queue_count, 0);
      chk("t5_wack", writeack_out, 0);
      step(0, 0, 0, 0, 16'h0);
      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         bit ld = ($urandom % 16) == 0;
         if (ld) begin
            cur_c = 8'($urandom_range(0, 202)); cur_h = 1'($urandom); cur_s = 2'($urandom);
         end
         step(ld, ($urandom % 3) == 0, m_req ? 1'($urandom) : (($urandom % 4) == 0),
              ($urandom % 40) == 0, 16'($urandom));
      end
      drain();
      // full logical sector plus one runaway word
      cur_c = 202; cur_h = 1; cur_s = 1;
      acked.delete(); w0 = wack_total;
      step(1, 0, 0, 0, 16'h0);
      for (int i = 0; i < 322; i++) begin
         step(0, 1, 0, 0, 16'($urandom));
         drain();
      end
      chk("t7_nacks", wack_total - w0, BOUNDS ? 321 : 322);
      chk("t7_ovf", overflow_error, BOUNDS);
      chk("t7_last", acked.size() > 0 ? acked[acked.size()-1] : -1,
          202 * 4096 + 2048 + 512 + (BOUNDS ? 320 : 321));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/buswrite_dram_queue.md
# buswrite_dram_queue

Write-side staging queue between `bus_disk_write` and the SDRAM controller.
- Accepts the single-cycle word strobes and the sector address-load pulse from the bus write deserializer.
- Tags each word with its full SDRAM word address and buffers it in a small FIFO.
- Presents words to the SDRAM controller through a req/ack handshake, so controller latency never loses a word mid-sector.
- Returns a per-word acknowledge upstream and flags overflow.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- WORDS_MAX, 321, data words per logical sector; used only by the bounds check.

Ports:
- clock  in  1  master clock, 40 MHz.
- reset  in  1  synchronous, active-high.
- flush  in  1  level; discard all queued words (driven when Selected_Ready drops).
- load_address_in  in  1  pulse; latch a new sector base address.
- cylinder  in  8  cylinder of the addressed sector, 0..202.
- head  in  1  head select.
- sector  in  2  logical sector, 0..3.
- write_enbl_in  in  1  pulse; enqueue writedata_in.
- writedata_in  in  16  data word.
- dram_ack  in  1  pulse; SDRAM controller accepted the word at the queue head.
- dram_req  out  1  head entry valid and offered.
- dram_addr  out  20  word address of the head entry: {cylinder, head, sector, offset[8:0]}.
- dram_data  out  16  data of the head entry.
- writeack_out  out  1  one-cycle pulse per word committed to SDRAM.
- overflow_error  out  1  sticky; a word was dropped.
- queue_count  out  $clog2(DEPTH)+1  entries held.

## Operation
- Base register {cylinder, head, sector} is captured on load_address_in, and offset is cleared to 0.
- Each enqueue stores the entry {base, offset}, then increments offset. Offset is 9 bits and wraps from 511 to 0.
- Entries keep their own address. A load_address_in while words are still pending does not alter those words.
- When load_address_in and write_enbl_in arrive in the same cycle, the new base is used with offset 0.
- Enqueue while full:
  - The word is dropped, overflow_error is set, and offset still increments.
  - If a pop happens in the same cycle, the enqueue is accepted and nothing is dropped.
- overflow_error clears on load_address_in or reset.
- Handshake state machine:
  - IDLE: dram_req=0. Goes to REQ when queue_count>0.
  - REQ: dram_req=1, with dram_addr/dram_data held stable. On dram_ack, pop the head and go to HOLD.
  - HOLD: dram_req=0 for exactly one cycle, and writeack_out=1. Then go to REQ if entries remain, otherwise IDLE.
- dram_ack outside REQ is ignored.
- flush (highest priority):
  - Empties the FIFO, goes to IDLE, and forces dram_req=0.
  - A dram_ack in the same cycle is ignored, and no writeack_out is produced for it.
  - Base, offset and overflow_error are unaffected.
  - Enqueues are refused while flush is high.
- Reset values: dram_req=0, dram_addr=0, dram_data=0, writeack_out=0, overflow_error=0, queue_count=0, state IDLE, base=0, offset=0.

## Timing
- Enqueue in cycle N: queue_count updates at N+1. From IDLE, dram_req rises at N+1.
- dram_ack in cycle M: pop at M+1, writeack_out high during M+1, next dram_req no earlier than M+2.
- The minimum turnaround is therefore 2 cycles per word; sustained throughput is 1 word per 2 clocks.
  - The bus delivers 1 word per about 28 µs, so DEPTH=4 covers roughly 100 µs of controller stall.
- dram_addr/dram_data are registered and change only on the cycle after a pop or flush.

## Configuration
- SECTOR_BOUNDS_CHECK_EN defined:
  - An enqueue when offset ≥ WORDS_MAX is dropped and sets overflow_error.
  - Offset saturates at WORDS_MAX instead of wrapping, which protects the next sector's SDRAM region from a runaway writer.
- Undefined: no bounds check, and offset wraps mod 512.

## Structure
- Shared package holds:
  - SDRAM address field widths: CYL_W=8, HEAD_W=1, SECT_W=2, OFFS_W=9, ADDR_W=20.
  - The handshake state encodings, IDLE/REQ/HOLD.
  - The WORDS_MAX default.
- One sub-module, `sync_fifo_addr_data`, holds the storage: a DEPTH × 36-bit register FIFO with wr_en/rd_en/count, a full/empty pair, and a flush.
- Address tagging, the FSM and the error logic live in the top.

## Test plan
- Load cylinder 5, head 1, sector 2, then 3 word strobes with data 0x1111/0x2222/0x3333, dram_ack 1 cycle after each req:
  - dram_addr sequence is 0x05C00, 0x05C01, 0x05C02, with matching data.
  - 3 writeack_out pulses.
- Hold dram_ack low and send 5 strobes (DEPTH=4):
  - queue_count=4, overflow_error=1, and the 5th word is never presented.
  - A later load_address_in clears overflow_error.
- With the queue full, send a strobe in the same cycle as dram_ack: no drop, overflow_error stays 0, and queue_count stays 4.
- Two words queued, then load sector 3, then one word:
  - The first two keep their old sector-2 addresses.
  - The third is at {cyl, head, 3, 0}.
- flush asserted while in REQ with 3 entries and a coincident dram_ack:
  - dram_req=0 the next cycle, queue_count=0, no writeack_out.
- With SECTOR_BOUNDS_CHECK_EN, send 322 strobes with immediate acks: 321 words written with offsets 0..320, the 322nd is dropped, and overflow_error=1.
